queue2: RTL and testbench

queue2 is the parametrised successor to the team's single-clock FIFO. It is a circular buffer of 2^DEPTH_BITS entries of DATA_BITS each, and it adds:
- a selectable first-word-fall-through (FWFT) output mode;
- occupancy and room counts;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- a synchronous flush.
It sits between producer/consumer blocks, such as UART and bus bridges, in the same clock domain.

---
 rtl/queue_pkg.sv | 13 +
 rtl/queue2_ram.sv | 17 +
 rtl/queue2.sv | 86 ++++++++
 tb/tb_queue2.sv | 113 +++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// queue_pkg: shared constants and helpers for the queue family
package queue_pkg;
  localparam int QUEUE_MODE_STD = 0;
  localparam int QUEUE_MODE_FWFT = 1;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int level_bits(input int depth_bits);
    return depth_bits + 1;
  endfunction
endpackage

// File: rtl/queue2_ram.sv
// queue2_ram: simple dual-port memory, synchronous write, asynchronous read
module queue2_ram #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk_i)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/queue2.sv
// queue2: circular FIFO with FWFT option, level/room counts, thresholds, sticky error flags and flush
module queue2
  import queue_pkg::*;
#(
  parameter int DEPTH_BITS = 3,
  parameter int DATA_BITS = 8,
  parameter int FWFT = QUEUE_MODE_STD,
  parameter int AFULL_LEVEL = (1 << DEPTH_BITS) - 1,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clr_i,
  input  logic [DATA_BITS-1:0]  dat_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  output logic [DATA_BITS-1:0]  dat_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  afull_o,
  output logic                  aempty_o,
  output logic [DEPTH_BITS:0]   level_o,
  output logic [DEPTH_BITS:0]   room_o,
  output logic                  ovf_o,
  output logic                  unf_o,
  output logic [DEPTH_BITS-1:0] rp_to,
  output logic [DEPTH_BITS-1:0] wp_to
);
  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int LW = level_bits(DEPTH_BITS);
  localparam int AW = clog2(DEPTH);
  if (AFULL_LEVEL < 0 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $error("queue2: AFULL_LEVEL out of range");
  end
  if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH) begin : g_bad_aempty
    $error("queue2: AEMPTY_LEVEL out of range");
  end
  logic [AW-1:0] rp, wp;
  logic [LW-1:0] level;
  logic [DATA_BITS-1:0] rd, dat_q;
  logic ovf, unf, pop_ok, push_ok;
  assign empty_o = level == '0;
  assign full_o = level == LW'(DEPTH);
  assign afull_o = level >= LW'(AFULL_LEVEL);
  assign aempty_o = level <= LW'(AEMPTY_LEVEL);
  assign level_o = level;
  assign room_o = LW'(DEPTH) - level;
  assign ovf_o = ovf;
  assign unf_o = unf;
  assign rp_to = rp;
  assign wp_to = wp;
  // a pop while full frees the slot the concurrent push needs
  assign pop_ok = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  queue2_ram #(.AW(AW), .DW(DATA_BITS)) u_ram (
    .clk_i(clk_i),
    .we(push_ok & ~clr_i),
    .wa(wp),
    .wd(dat_i),
    .ra(rp),
    .rd(rd)
  );
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      rp <= '0;
      wp <= '0;
      level <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      dat_q <= '0;
    end else if (clr_i) begin
      rp <= '0;
      wp <= '0;
      level <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (pop_ok) rp <= rp + AW'(1);
      if (push_ok) wp <= wp + AW'(1);
      if (pop_ok) dat_q <= rd;
      level <= level + LW'(push_ok) - LW'(pop_ok);
      ovf <= ovf | (push_i & ~push_ok);
      unf <= unf | (pop_i & ~pop_ok);
    end
  assign dat_o = (FWFT == QUEUE_MODE_FWFT) ? rd : dat_q;
endmodule

// File: tb/tb_queue2.sv
// tb_queue2: randomized and directed checks of queue2 (std and FWFT) against a queue-based model
module tb_queue2;
  logic clk_i = 0, reset_i = 0, clr_i = 0, push_i = 0, pop_i = 0;
  logic [7:0] dat_i = 0;
  logic [7:0] d0, d1;
  logic full0, empty0, af0, ae0, ovf0, unf0, full1, empty1, af1, ae1, ovf1, unf1;
  logic [3:0] lvl0, room0, lvl1, room1;
  logic [2:0] rp0, wp0, rp1, wp1;
  int checks = 0, errors = 0;
  byte unsigned q[$];
  int m_rp, m_wp;
  bit m_ovf, m_unf;
  byte unsigned m_dat;

  always #5 clk_i = ~clk_i;

  queue2 #(.FWFT(0)) u0 (.clk_i(clk_i), .reset_i(reset_i), .clr_i(clr_i), .dat_i(dat_i),
    .push_i(push_i), .pop_i(pop_i), .dat_o(d0), .full_o(full0), .empty_o(empty0),
    .afull_o(af0), .aempty_o(ae0), .level_o(lvl0), .room_o(room0), .ovf_o(ovf0),
    .unf_o(unf0), .rp_to(rp0), .wp_to(wp0));
  queue2 #(.FWFT(1)) u1 (.clk_i(clk_i), .reset_i(reset_i), .clr_i(clr_i), .dat_i(dat_i),
    .push_i(push_i), .pop_i(pop_i), .dat_o(d1), .full_o(full1), .empty_o(empty1),
    .afull_o(af1), .aempty_o(ae1), .level_o(lvl1), .room_o(room1), .ovf_o(ovf1),
    .unf_o(unf1), .rp_to(rp1), .wp_to(wp1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n = q.size();
    chk({tag, " level"}, 32'(lvl0), n);
    chk({tag, " room"}, 32'(room0), 8 - n);
    chk({tag, " full"}, 32'(full0), n == 8);
    chk({tag, " empty"}, 32'(empty0), n == 0);
    chk({tag, " afull"}, 32'(af0), n >= 7);
    chk({tag, " aempty"}, 32'(ae0), n <= 1);
    chk({tag, " ovf"}, 32'(ovf0), m_ovf);
    chk({tag, " unf"}, 32'(unf0), m_unf);
    chk({tag, " rp"}, 32'(rp0), m_rp);
    chk({tag, " wp"}, 32'(wp0), m_wp);
    chk({tag, " dat_std"}, 32'(d0), m_dat);
    chk({tag, " fwft_state"}, {lvl1, room1, full1, empty1, af1, ae1, ovf1, unf1, rp1, wp1},
        {lvl0, room0, full0, empty0, af0, ae0, ovf0, unf0, rp0, wp0});
    if (n > 0) chk({tag, " dat_fwft"}, 32'(d1), q[0]);
  endtask

  task automatic model_reset();
    q.delete();
    m_rp = 0; m_wp = 0; m_ovf = 0; m_unf = 0; m_dat = 0;
  endtask

  task automatic step(input string tag, input bit push, input bit pop, input byte unsigned d, input bit clr = 0);
    bit pop_ok, push_ok;
    push_i = push; pop_i = pop; dat_i = d; clr_i = clr;
    @(posedge clk_i);
    if (clr) begin
      q.delete();
      m_rp = 0; m_wp = 0; m_ovf = 0; m_unf = 0;
    end else begin
      pop_ok = pop && q.size() > 0;
      push_ok = push && (q.size() < 8 || pop_ok);
      if (pop_ok) begin m_dat = q.pop_front(); m_rp = (m_rp + 1) % 8; end
      if (push_ok) begin q.push_back(d); m_wp = (m_wp + 1) % 8; end
      if (push && !push_ok) m_ovf = 1;
      if (pop && !pop_ok) m_unf = 1;
    end
    #1;
    push_i = 0; pop_i = 0; clr_i = 0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 check_all("reset");
    reset_i = 1;
    for (int i = 1; i <= 8; i++) step("fill", 1, 0, 8'(i));
    step("fill_ovf", 1, 0, 8'hFF);
    for (int i = 0; i < 9; i++) step("drain", 0, 1, 8'h00);
    step("clr", 0, 0, 0, 1);
    step("fwft_a5", 1, 0, 8'hA5);
    step("fwft_5a", 1, 0, 8'h5A);
    step("fwft_pop1", 0, 1, 0);
    step("fwft_pop2", 0, 1, 0);
    for (int i = 0; i < 8; i++) step("refill", 1, 0, 8'($urandom));
    step("full_pushpop", 1, 1, 8'h77);
    step("clr2", 0, 0, 0, 1);
    step("empty_pushpop", 1, 1, 8'h3C);
    for (int i = 0; i < 3; i++) step("to4", 1, 0, 8'($urandom));
    for (int i = 0; i < 20; i++) step("wrap", i % 2 == 0, i % 2 == 1, 8'($urandom));
    for (int i = 0; i < 300; i++)
      step("rand", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom),
           $urandom_range(0, 40) == 0);
    step("clr3", 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) step("ovf_fill", 1, 0, 8'($urandom));
    for (int i = 0; i < 3; i++) step("to5", 0, 1, 0);
    step("clr_prio", 1, 1, 8'h55, 1);
    for (int i = 0; i < 4; i++) step("pre_rst", 1, 0, 8'($urandom));
    #3 reset_i = 0;
    model_reset();
    #1 check_all("async_rst");
    #2 reset_i = 1;
    step("post_rst", 1, 0, 8'h99);
    step("post_rst_pop", 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
